// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory stage: FSM states,
// RISC-V funct3 size/sign codes, byte-enable patterns and a legality helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'd0, shifted[7:0]};
            F3_LHU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one word-aligned request with byte enables per op,
// ready handshake, extended load data. Define LSU_MISALIGN_FAULT_EN to fault
// misaligned halfword/word accesses instead of forcing natural alignment.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t  state_reg, state_next;
    logic [2:0]  funct3_reg;
    logic [1:0]  addr_lo_reg;
    logic [1:0]  addr_lo_eff;
    logic        op_fault;
    logic        accept, reject, complete;
    logic [3:0]  be_next;
    logic [31:0] wdata_lanes;
    logic [31:0] load_value;

    // Decode of the incoming op; only meaningful while IDLE samples start.
    always_comb begin
        case (funct3[1:0])
            2'b01:   addr_lo_eff = {addr[1], 1'b0};
            2'b10:   addr_lo_eff = 2'b00;
            default: addr_lo_eff = addr[1:0];
        endcase
`ifdef LSU_MISALIGN_FAULT_EN
        op_fault = !funct3_legal(we, funct3) ||
                   ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        op_fault = !funct3_legal(we, funct3);
`endif
        case (funct3[1:0])
            2'b00:   be_next = BE_BYTE << addr_lo_eff;
            2'b01:   be_next = addr_lo_eff[1] ? BE_HALF_HI : BE_HALF_LO;
            default: be_next = BE_WORD;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_lanes[8*gi +: 8] = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                                        (funct3[1:0] == 2'b01) ? wdata[8*(gi%2) +: 8] :
                                                                 wdata[8*gi +: 8];
    end

    assign accept   = (state_reg == S_IDLE) && start && !op_fault;
    assign reject   = (state_reg == S_IDLE) && start && op_fault;
    assign complete = (state_reg == S_REQ) && mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = op_fault ? S_FAULT : S_REQ;
            S_REQ:   if (mem_ready) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = ((state_reg == S_IDLE) && start) || (state_reg == S_REQ);
    end

    lsu_load_align u_load_align (
        .mem_rdata (mem_rdata),
        .funct3    (funct3_reg),
        .addr_lo   (addr_lo_reg),
        .load_data (load_value)
    );

    // Memory-side outputs are loaded on accept and held untouched through REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done        <= 1'b0;
            fault       <= 1'b0;
            rdata       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            funct3_reg  <= '0;
            addr_lo_reg <= '0;
        end else begin
            done  <= (state_next == S_DONE) || (state_next == S_FAULT);
            fault <= (state_next == S_FAULT);
            if (accept) begin
                mem_req     <= 1'b1;
                mem_we      <= we;
                mem_addr    <= {addr[ADDR_W-1:2], 2'b00};
                mem_be      <= be_next;
                mem_wdata   <= wdata_lanes;
                funct3_reg  <= funct3;
                addr_lo_reg <= addr_lo_eff;
            end
            if (reject)
                rdata <= '0;
            if (complete) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (!mem_we)
                    rdata <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed ops, a byte-lane model and
// a per-cycle compare process against the expected handshake timeline.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    lsu_mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int offset(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        return ((a % 4) / n) * n;
    endfunction

    function automatic logic m_fault(input logic w, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1'b1;
`ifdef LSU_MISALIGN_FAULT_EN
        if ((a % nbytes(f3)) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        int mask = (1 << n) - 1;
        return 4'((mask << offset(f3, a)) & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r = 0;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++)
            r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(f3);
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        logic [31:0] v = rd >> (8 * offset(f3, a));
        v = v & mask[31:0];
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask[31:0];
        return v;
    endfunction

    // ---------------- expected timeline and observations ----------------
    typedef enum int {P_NONE, P_START, P_REQ, P_DONE, P_FAULT, P_IDLE} phase_t;
    phase_t phase = P_NONE;

    logic        e_we, e_hold;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    int          start_cyc;

    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;
    int          obs_lat;
    logic        obs_req_seen, obs_fault_seen;

    always @(negedge clk) begin
        if (!rst && phase != P_NONE) begin
            if (mem_req === 1'b1) obs_req_seen = 1'b1;
            case (phase)
                P_START: begin
                    chk("start_busy", 32'(busy), 32'd1);
                    chk("start_done", 32'(done), 32'd0);
                    chk("start_req", 32'(mem_req), 32'd0);
                end
                P_REQ: begin
                    chk("req_busy", 32'(busy), 32'd1);
                    chk("req_done", 32'(done), 32'd0);
                    chk("req_mem_req", 32'(mem_req), 32'd1);
                    chk("req_mem_we", 32'(mem_we), 32'(e_we));
                    chk("req_mem_addr", mem_addr, e_addr);
                    chk("req_mem_be", 32'(mem_be), 32'(e_be));
                    if (e_we) chk("req_mem_wdata", mem_wdata, e_wdata);
                    obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
                end
                P_DONE: begin
                    chk("done_done", 32'(done), 32'd1);
                    chk("done_fault", 32'(fault), 32'd0);
                    chk("done_busy", 32'(busy), 32'd0);
                    chk("done_req", 32'(mem_req), 32'd0);
                    if (!e_we) chk("done_rdata", rdata, e_rdata);
                    obs_rdata = rdata;
                    obs_lat = cyc - start_cyc + 1;
                end
                P_FAULT: begin
                    chk("fault_done", 32'(done), 32'd1);
                    chk("fault_fault", 32'(fault), 32'd1);
                    chk("fault_busy", 32'(busy), 32'd0);
                    chk("fault_req", 32'(mem_req), 32'd0);
                    chk("fault_rdata", rdata, 32'd0);
                    obs_fault_seen = 1'b1;
                    obs_lat = cyc - start_cyc + 1;
                end
                P_IDLE: begin
                    chk("idle_done", 32'(done), 32'd0);
                    chk("idle_fault", 32'(fault), 32'd0);
                    chk("idle_busy", 32'(busy), 32'd0);
                    chk("idle_req", 32'(mem_req), 32'd0);
                    if (e_hold) chk("idle_rdata_hold", rdata, e_rdata);
                end
                default: ;
            endcase
        end
    end

    // Drives one op; phases follow the required timeline, never DUT outputs.
    task automatic run_op(input logic op_we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int wait_n, input bit poke_start);
        logic flt;
        flt     = m_fault(op_we, f3, a);
        e_we    = op_we;
        e_addr  = a & ~32'd3;
        e_be    = flt ? 4'd0 : m_be(f3, a);
        e_wdata = flt ? 32'd0 : m_wdata(f3, wd);
        e_rdata = (flt || op_we) ? 32'd0 : m_rdata(f3, a, rd);
        e_hold  = flt || !op_we;
        obs_req_seen = 1'b0; obs_fault_seen = 1'b0; obs_lat = 0;
        obs_addr = 'x; obs_be = 'x; obs_wdata = 'x; obs_rdata = 'x;

        start = 1'b1; we = op_we; funct3 = f3; addr = a; wdata = wd;
        mem_ready = 1'b0; mem_rdata = $urandom;
        start_cyc = cyc; phase = P_START;
        @(posedge clk); #1;
        start = 1'b0;
        if (flt) begin
            phase = P_FAULT;
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i <= wait_n; i++) begin
                phase = P_REQ;
                if (i == 0 && poke_start) begin
                    start = 1'b1; we = ~op_we; funct3 = 3'b010; addr = a + 32'h40;
                end else begin
                    start = 1'b0;
                end
                mem_ready = (i == wait_n);
                mem_rdata = (i == wait_n) ? rd : $urandom;
                @(posedge clk); #1;
            end
            start = 1'b0;
            phase = P_DONE;
            mem_ready = 1'b1; mem_rdata = $urandom;
            @(posedge clk); #1;
        end
        phase = P_IDLE;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        phase = P_NONE;
        $display("op we=%0d f3=%03b addr=%h wdata=%h -> fault=%0d be=%h mem_wdata=%h rdata=%h lat=%0d",
                 op_we, f3, a, wd, obs_fault_seen, obs_be, obs_wdata, obs_rdata, obs_lat);
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          wt;
    } vec_t;

    vec_t vecs[6] = '{
        '{1'b1, 3'b000, 32'h0000_0041, 32'h0000_00A5, 32'h0,         0},
        '{1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h8001_1234, 1},
        '{1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'h8001_1234, 0},
        '{1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,         2},
        '{1'b1, 3'b100, 32'h0000_0020, 32'h1111_2222, 32'h0,         0},
        '{1'b0, 3'b001, 32'h0000_0013, 32'h0,         32'hABCD_7654, 0}
    };

    initial begin
        rst = 1'b1; start = 1'b0; we = 1'b0; funct3 = 3'b0; addr = 32'h0;
        wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        chk("lw_addr_lit", obs_addr, 32'h100);
        chk("lw_be_lit", 32'(obs_be), 32'hF);
        chk("lw_latency_lit", 32'(obs_lat), 32'd3);
        chk("lw_rdata_lit", obs_rdata, 32'hDEADBEEF);

        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1'b0);
        chk("lb_be_lit", 32'(obs_be), 32'h8);
        chk("lb_rdata_lit", obs_rdata, 32'hFFFFFF80);
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1'b0);
        chk("lbu_rdata_lit", obs_rdata, 32'h00000080);

        run_op(1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 3, 1'b1);
        chk("sh_be_lit", 32'(obs_be), 32'hC);
        chk("sh_wdata_lit", obs_wdata, 32'hABCDABCD);
        chk("sh_latency_lit", 32'(obs_lat), 32'd6);

        run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h55AA_33CC, 0, 1'b0);
`ifdef LSU_MISALIGN_FAULT_EN
        chk("lw_mis_req_lit", 32'(obs_req_seen), 32'd0);
        chk("lw_mis_fault_lit", 32'(obs_fault_seen), 32'd1);
        chk("lw_mis_lat_lit", 32'(obs_lat), 32'd2);
`else
        chk("lw_mis_addr_lit", obs_addr, 32'h100);
        chk("lw_mis_rdata_lit", obs_rdata, 32'h55AA_33CC);
`endif

        run_op(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 0, 1'b0);
        chk("f3_011_fault_lit", 32'(obs_fault_seen), 32'd1);
        chk("f3_011_req_lit", 32'(obs_req_seen), 32'd0);

        foreach (vecs[i])
            run_op(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].wt, 1'b0);

        // Reset while a request is outstanding.
        e_we = 1'b0; e_addr = 32'h200; e_be = 4'hF; e_hold = 1'b0;
        start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h200; mem_ready = 1'b0;
        start_cyc = cyc; phase = P_START;
        @(posedge clk); #1;
        phase = P_REQ; start = 1'b0;
        @(posedge clk); #1;
        phase = P_NONE;
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_mem_be", 32'(mem_be), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_req", 32'(mem_req), 32'd0);
        $display("op reset during REQ at addr=00000200 -> mem_req=%0d busy=%0d", mem_req, busy);

        run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
        chk("post_rst_lw_lit", obs_rdata, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
